// File: rtl/modelbuf_read_arbiter_if.sv
// Bus bundle for the model-buffer read arbiter: requester-side request/response
// ports plus the shared model-buffer port. The payload types live here so the
// arbiter and its environment agree on them without a separate package.
interface modelbuf_read_arbiter_if #(
  parameter int NUM_REQ = 2
);
  typedef struct packed {
    logic [7:0]  model_index;
    logic [15:0] triangle_index;
  } modelbuf_read_t;

  typedef struct packed {
    logic [15:0] v0;
    logic [15:0] v1;
    logic [15:0] v2;
  } triangle_t;

  typedef struct packed {
    logic       last;
    logic [7:0] model_index;
  } triangle_meta_t;

  // requester side
  logic           [NUM_REQ-1:0] req_valid;
  logic           [NUM_REQ-1:0] req_ready;
  modelbuf_read_t [NUM_REQ-1:0] req_data;
  logic           [NUM_REQ-1:0] rsp_valid;
  logic           [NUM_REQ-1:0] rsp_ready;
  triangle_t                    rsp_data;
  triangle_meta_t               rsp_metadata;

  // model-buffer side
  logic           mb_req_valid;
  logic           mb_req_ready;
  modelbuf_read_t mb_req_data;
  logic           mb_rsp_valid;
  logic           mb_rsp_ready;
  triangle_t      mb_rsp_data;
  triangle_meta_t mb_rsp_metadata;

  // the arbiter
  modport master (
    input  req_valid, req_data, rsp_ready,
    input  mb_req_ready, mb_rsp_valid, mb_rsp_data, mb_rsp_metadata,
    output req_ready, rsp_valid, rsp_data, rsp_metadata,
    output mb_req_valid, mb_req_data, mb_rsp_ready
  );

  // requesters + model buffer
  modport slave (
    output req_valid, req_data, rsp_ready,
    output mb_req_ready, mb_rsp_valid, mb_rsp_data, mb_rsp_metadata,
    input  req_ready, rsp_valid, rsp_data, rsp_metadata,
    input  mb_req_valid, mb_req_data, mb_rsp_ready
  );
endinterface

// File: rtl/modelbuf_read_arbiter.sv
// Round-robin arbiter sharing the model-buffer read port between NUM_REQ
// triangle-fetch requesters. Granted indices go into an in-order tag FIFO so
// each returning beat is steered back to its issuer.
// Optional: `define MODELBUF_ARB_LOCK_EN to lock arbitration to one requester
// until that requester's final (last=1) triangle has been returned.
module modelbuf_read_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int TAG_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rstn,
  modelbuf_read_arbiter_if.master        bus,
  output logic [$clog2(TAG_DEPTH+1)-1:0] outstanding,
  output logic                           err_orphan_rsp
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PTR_W = $clog2(TAG_DEPTH);
  localparam int CNT_W = $clog2(TAG_DEPTH + 1);

  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             hold_q, hold_d;
  logic [IDX_W-1:0] hold_idx_q, hold_idx_d;
  logic [IDX_W-1:0] tag_q [TAG_DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic [NUM_REQ-1:0] elig;
  logic [IDX_W-1:0]   pick, grant, head;
  logic               any_req, fifo_full, fifo_empty, push, pop;

  assign fifo_full  = (cnt_q == CNT_W'(TAG_DEPTH));
  assign fifo_empty = (cnt_q == '0);
  assign head       = tag_q[rptr_q];

`ifdef MODELBUF_ARB_LOCK_EN
  logic             lock_valid_q, lock_valid_d;
  logic [IDX_W-1:0] lock_id_q, lock_id_d;

  // while locked only the lock owner may compete
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++)
      elig[i] = bus.req_valid[i] && (!lock_valid_q || lock_id_q == IDX_W'(i));
  end

  // lock on the first unlocked handshake; release once the owner's last beat is taken
  always_comb begin
    lock_valid_d = lock_valid_q;
    lock_id_d    = lock_id_q;
    if (pop && head == lock_id_q && bus.mb_rsp_metadata.last && lock_valid_q)
      lock_valid_d = 1'b0;
    else if (push && !lock_valid_q) begin
      lock_valid_d = 1'b1;
      lock_id_d    = grant;
    end
  end

  // lock state register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      lock_valid_q <= 1'b0;
      lock_id_q    <= '0;
    end else begin
      lock_valid_q <= lock_valid_d;
      lock_id_q    <= lock_id_d;
    end
  end
`else
  assign elig = bus.req_valid;
`endif

  // first eligible requester strictly after rr_ptr, wrapping
  always_comb begin
    int  idx;
    logic found;
    pick  = rr_ptr_q;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!found && elig[idx]) begin
        found = 1'b1;
        pick  = IDX_W'(idx);
      end
    end
  end

  // a stalled grant is pinned so the offered request cannot change under the buffer
  assign grant            = hold_q ? hold_idx_q : pick;
  assign any_req          = hold_q || (|elig);
  assign bus.mb_req_valid = any_req && !fifo_full;
  assign bus.mb_req_data  = bus.req_data[grant];
  assign push             = bus.mb_req_valid && bus.mb_req_ready;

  // only the granted requester sees its handshake
  always_comb begin
    bus.req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant == IDX_W'(i)) bus.req_ready[i] = push;
  end

  // responses go to the oldest outstanding tag; nothing is accepted without one
  assign bus.mb_rsp_ready = !fifo_empty && bus.rsp_ready[head];
  assign pop              = bus.mb_rsp_valid && bus.mb_rsp_ready;
  assign bus.rsp_data     = bus.mb_rsp_data;
  assign bus.rsp_metadata = bus.mb_rsp_metadata;

  // steer response valid to the head tag's requester
  always_comb begin
    bus.rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++)
      bus.rsp_valid[i] = bus.mb_rsp_valid && !fifo_empty && head == IDX_W'(i);
  end

  // next-state for arbitration, FIFO pointers/occupancy and orphan flag
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    hold_d     = hold_q;
    hold_idx_d = hold_idx_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    cnt_d      = cnt_q + CNT_W'(push) - CNT_W'(pop);
    err_d      = err_q | (bus.mb_rsp_valid && fifo_empty);
    if (push) begin
      rr_ptr_d = grant;
      hold_d   = 1'b0;
      wptr_d   = wptr_q + PTR_W'(1);
    end else if (bus.mb_req_valid) begin
      hold_d     = 1'b1;
      hold_idx_d = grant;
    end
    if (pop) rptr_d = rptr_q + PTR_W'(1);
  end

  // control state register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rr_ptr_q   <= IDX_W'(NUM_REQ - 1);
      hold_q     <= 1'b0;
      hold_idx_q <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      hold_q     <= hold_d;
      hold_idx_q <= hold_idx_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  // tag storage; contents are don't-care while the FIFO is empty
  always_ff @(posedge clk) begin
    if (push) tag_q[wptr_q] <= grant;
  end

  assign outstanding    = cnt_q;
  assign err_orphan_rsp = err_q;
endmodule

// File: tb/tb_modelbuf_read_arbiter.sv
// Directed bench for modelbuf_read_arbiter (NUM_REQ=2, TAG_DEPTH=4).
module tb_modelbuf_read_arbiter;
  logic       clk = 1'b0;
  logic       rstn;
  logic [2:0] outstanding;
  logic       err_orphan_rsp;
  int checks = 0;
  int failures = 0;

  modelbuf_read_arbiter_if #(.NUM_REQ(2)) bus ();

  modelbuf_read_arbiter #(.NUM_REQ(2), .TAG_DEPTH(4)) dut (
    .clk(clk), .rstn(rstn), .bus(bus),
    .outstanding(outstanding), .err_orphan_rsp(err_orphan_rsp)
  );

  always #5 clk = ~clk;

  localparam logic [23:0] RA = {8'h01, 16'h0010};
  localparam logic [23:0] RB = {8'h02, 16'h0020};
  localparam logic [47:0] D0 = 48'h0100_0101_0102;
  localparam logic [47:0] D1 = 48'h0200_0201_0202;
  localparam logic [47:0] D2 = 48'h0300_0301_0302;

  task tick;
    @(posedge clk); #1;
  endtask

  task idle_inputs;
    bus.req_valid = 2'b00; bus.req_data[0] = RA; bus.req_data[1] = RB;
    bus.mb_req_ready = 1'b0; bus.mb_rsp_valid = 1'b0; bus.rsp_ready = 2'b00;
    bus.mb_rsp_data = '0; bus.mb_rsp_metadata = '0;
  endtask

  task apply_reset;
    rstn = 1'b0; idle_inputs(); tick(); tick(); rstn = 1'b1;
  endtask

  task test_reset;
    rstn = 1'b0; idle_inputs(); tick(); tick();
    checks++; if (outstanding !== 3'd0) begin failures++; $display("FAIL reset_outstanding got=%0d exp=0", outstanding); end
    checks++; if (err_orphan_rsp !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err_orphan_rsp); end
    checks++; if ({bus.mb_req_valid, bus.req_ready, bus.rsp_valid, bus.mb_rsp_ready} !== 6'b0) begin failures++;
      $display("FAIL reset_valids got=%b exp=000000", {bus.mb_req_valid, bus.req_ready, bus.rsp_valid, bus.mb_rsp_ready}); end
    rstn = 1'b1;
  endtask

  task test_hold;
    apply_reset();
    bus.req_valid = 2'b10; bus.mb_req_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) bus.req_valid = 2'b11;
      #1;
      checks++; if (bus.mb_req_valid !== 1'b1 || bus.mb_req_data !== RB || bus.req_ready !== 2'b00) begin failures++;
        $display("FAIL hold_stall%0d got v=%b d=%h rdy=%b exp v=1 d=%h rdy=00", c, bus.mb_req_valid, bus.mb_req_data, bus.req_ready, RB); end
      tick();
    end
    bus.mb_req_ready = 1'b1; #1;
    checks++; if (bus.req_ready !== 2'b10 || bus.mb_req_data !== RB) begin failures++;
      $display("FAIL hold_release got rdy=%b d=%h exp rdy=10 d=%h", bus.req_ready, bus.mb_req_data, RB); end
    tick(); #1;
    checks++; if (bus.req_ready !== 2'b01 || bus.mb_req_data !== RA) begin failures++;
      $display("FAIL hold_next_grant got rdy=%b d=%h exp rdy=01 d=%h", bus.req_ready, bus.mb_req_data, RA); end
    tick();
    bus.req_valid = 2'b00; bus.mb_req_ready = 1'b0;
    checks++; if (outstanding !== 3'd2) begin failures++; $display("FAIL hold_outstanding got=%0d exp=2", outstanding); end
    bus.mb_rsp_valid = 1'b1; bus.rsp_ready = 2'b11; #1;
    checks++; if (bus.rsp_valid !== 2'b10) begin failures++; $display("FAIL hold_rsp0 got=%b exp=10", bus.rsp_valid); end
    tick(); #1;
    checks++; if (bus.rsp_valid !== 2'b01) begin failures++; $display("FAIL hold_rsp1 got=%b exp=01", bus.rsp_valid); end
    tick(); bus.mb_rsp_valid = 1'b0;
    checks++; if (outstanding !== 3'd0) begin failures++; $display("FAIL hold_drain got=%0d exp=0", outstanding); end
  endtask

  task test_alternation;
    logic [1:0] exp_rsp [3];
    apply_reset();
    bus.req_valid = 2'b11; bus.mb_req_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (bus.req_ready !== ((k % 2) ? 2'b10 : 2'b01)) begin failures++;
        $display("FAIL alt_grant%0d got=%b exp=%b", k, bus.req_ready, (k % 2) ? 2'b10 : 2'b01); end
      tick();
    end
    #1;
    checks++; if (outstanding !== 3'd4 || bus.mb_req_valid !== 1'b0 || bus.req_ready !== 2'b00) begin failures++;
      $display("FAIL alt_full got occ=%0d v=%b rdy=%b exp occ=4 v=0 rdy=00", outstanding, bus.mb_req_valid, bus.req_ready); end
    // pop while full: no push that cycle
    bus.mb_rsp_valid = 1'b1; bus.rsp_ready = 2'b11; #1;
    checks++; if (bus.mb_req_valid !== 1'b0 || bus.rsp_valid !== 2'b01) begin failures++;
      $display("FAIL alt_full_pop got v=%b rsp=%b exp v=0 rsp=01", bus.mb_req_valid, bus.rsp_valid); end
    tick();
    checks++; if (outstanding !== 3'd3) begin failures++; $display("FAIL alt_after_pop got=%0d exp=3", outstanding); end
    // simultaneous push and pop
    #1;
    checks++; if (bus.req_ready !== 2'b01 || bus.rsp_valid !== 2'b10) begin failures++;
      $display("FAIL alt_pushpop got rdy=%b rsp=%b exp rdy=01 rsp=10", bus.req_ready, bus.rsp_valid); end
    tick();
    checks++; if (outstanding !== 3'd3) begin failures++; $display("FAIL alt_pushpop_occ got=%0d exp=3", outstanding); end
    bus.req_valid = 2'b00;
    exp_rsp[0] = 2'b01; exp_rsp[1] = 2'b10; exp_rsp[2] = 2'b01;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (bus.rsp_valid !== exp_rsp[k]) begin failures++;
        $display("FAIL alt_drain%0d got=%b exp=%b", k, bus.rsp_valid, exp_rsp[k]); end
      tick();
    end
    bus.mb_rsp_valid = 1'b0;
    checks++; if (outstanding !== 3'd0) begin failures++; $display("FAIL alt_empty got=%0d exp=0", outstanding); end
  endtask

  task test_routing;
    apply_reset();
    bus.req_valid = 2'b11; bus.mb_req_ready = 1'b1;
    tick(); tick(); tick();
    bus.req_valid = 2'b00; bus.mb_req_ready = 1'b0;
    checks++; if (outstanding !== 3'd3) begin failures++; $display("FAIL route_occ got=%0d exp=3", outstanding); end
    bus.mb_rsp_valid = 1'b1; bus.rsp_ready = 2'b01; bus.mb_rsp_data = D0; bus.mb_rsp_metadata = {1'b0, 8'h01}; #1;
    checks++; if (bus.rsp_valid !== 2'b01 || bus.mb_rsp_ready !== 1'b1 || bus.rsp_data !== D0 || bus.rsp_metadata !== {1'b0, 8'h01}) begin failures++;
      $display("FAIL route_beat0 got v=%b rdy=%b d=%h exp v=01 rdy=1 d=%h", bus.rsp_valid, bus.mb_rsp_ready, bus.rsp_data, D0); end
    tick();
    bus.mb_rsp_data = D1; bus.mb_rsp_metadata = {1'b1, 8'h02};
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++; if (bus.rsp_valid !== 2'b10 || bus.mb_rsp_ready !== 1'b0) begin failures++;
        $display("FAIL route_stall%0d got v=%b rdy=%b exp v=10 rdy=0", c, bus.rsp_valid, bus.mb_rsp_ready); end
      tick();
    end
    bus.rsp_ready = 2'b10; #1;
    checks++; if (bus.rsp_valid !== 2'b10 || bus.mb_rsp_ready !== 1'b1 || bus.rsp_data !== D1) begin failures++;
      $display("FAIL route_beat1 got v=%b rdy=%b d=%h exp v=10 rdy=1 d=%h", bus.rsp_valid, bus.mb_rsp_ready, bus.rsp_data, D1); end
    tick();
    bus.mb_rsp_data = D2; bus.rsp_ready = 2'b11; #1;
    checks++; if (bus.rsp_valid !== 2'b01 || bus.rsp_data !== D2) begin failures++;
      $display("FAIL route_beat2 got v=%b d=%h exp v=01 d=%h", bus.rsp_valid, bus.rsp_data, D2); end
    tick();
    bus.mb_rsp_valid = 1'b0;
    checks++; if (outstanding !== 3'd0 || err_orphan_rsp !== 1'b0) begin failures++;
      $display("FAIL route_done got occ=%0d err=%b exp occ=0 err=0", outstanding, err_orphan_rsp); end
  endtask

  task test_orphan;
    apply_reset();
    bus.mb_rsp_valid = 1'b1; bus.rsp_ready = 2'b11; #1;
    checks++; if (bus.mb_rsp_ready !== 1'b0 || bus.rsp_valid !== 2'b00 || err_orphan_rsp !== 1'b0) begin failures++;
      $display("FAIL orphan_comb got rdy=%b v=%b err=%b exp rdy=0 v=00 err=0", bus.mb_rsp_ready, bus.rsp_valid, err_orphan_rsp); end
    tick(); bus.mb_rsp_valid = 1'b0;
    checks++; if (err_orphan_rsp !== 1'b1) begin failures++; $display("FAIL orphan_set got=%b exp=1", err_orphan_rsp); end
    tick(); tick();
    checks++; if (err_orphan_rsp !== 1'b1) begin failures++; $display("FAIL orphan_sticky got=%b exp=1", err_orphan_rsp); end
    // response in the same cycle as the first push is still an orphan
    apply_reset();
    bus.req_valid = 2'b01; bus.mb_req_ready = 1'b1; bus.mb_rsp_valid = 1'b1; bus.rsp_ready = 2'b11; #1;
    checks++; if (bus.mb_rsp_ready !== 1'b0 || bus.req_ready !== 2'b01) begin failures++;
      $display("FAIL orphan_firstpush got rsprdy=%b reqrdy=%b exp rsprdy=0 reqrdy=01", bus.mb_rsp_ready, bus.req_ready); end
    tick(); bus.req_valid = 2'b00; bus.mb_rsp_valid = 1'b0;
    checks++; if (err_orphan_rsp !== 1'b1 || outstanding !== 3'd1) begin failures++;
      $display("FAIL orphan_firstpush_state got err=%b occ=%0d exp err=1 occ=1", err_orphan_rsp, outstanding); end
    rstn = 1'b0; tick(); rstn = 1'b1;
    checks++; if (err_orphan_rsp !== 1'b0) begin failures++; $display("FAIL orphan_clear got=%b exp=0", err_orphan_rsp); end
  endtask

  task test_reset_midburst;
    apply_reset();
    bus.req_valid = 2'b11; bus.mb_req_ready = 1'b1;
    tick(); tick(); tick();
    checks++; if (outstanding !== 3'd3) begin failures++; $display("FAIL mid_occ got=%0d exp=3", outstanding); end
    rstn = 1'b0; bus.req_valid = 2'b00; bus.mb_req_ready = 1'b0; bus.mb_rsp_valid = 1'b1; bus.rsp_ready = 2'b11;
    tick(); #1;
    checks++; if (outstanding !== 3'd0 || bus.mb_req_valid !== 1'b0 || bus.rsp_valid !== 2'b00 || bus.mb_rsp_ready !== 1'b0) begin failures++;
      $display("FAIL mid_reset got occ=%0d v=%b rsp=%b rdy=%b exp 0/0/00/0", outstanding, bus.mb_req_valid, bus.rsp_valid, bus.mb_rsp_ready); end
    bus.mb_rsp_valid = 1'b0; rstn = 1'b1;
    bus.req_valid = 2'b11; bus.mb_req_ready = 1'b1; #1;
    checks++; if (bus.req_ready !== 2'b01) begin failures++; $display("FAIL mid_first_grant got=%b exp=01", bus.req_ready); end
    tick(); bus.req_valid = 2'b00; bus.mb_req_ready = 1'b0;
  endtask

`ifdef MODELBUF_ARB_LOCK_EN
  task test_lock;
    apply_reset();
    bus.req_valid = 2'b11; bus.mb_req_ready = 1'b1; bus.rsp_ready = 2'b11; #1;
    checks++; if (bus.req_ready !== 2'b01) begin failures++; $display("FAIL lock_c1 got=%b exp=01", bus.req_ready); end
    tick(); #1;
    checks++; if (bus.req_ready !== 2'b01) begin failures++; $display("FAIL lock_c2 got=%b exp=01", bus.req_ready); end
    tick();
    bus.mb_rsp_valid = 1'b1; bus.mb_rsp_metadata = {1'b0, 8'h01}; #1;
    checks++; if (bus.req_ready !== 2'b01 || bus.rsp_valid !== 2'b01) begin failures++;
      $display("FAIL lock_c3 got rdy=%b rsp=%b exp rdy=01 rsp=01", bus.req_ready, bus.rsp_valid); end
    tick();
    bus.mb_rsp_metadata = {1'b1, 8'h01}; bus.req_valid = 2'b10; #1;
    checks++; if (bus.req_ready !== 2'b00 || bus.rsp_valid !== 2'b01) begin failures++;
      $display("FAIL lock_c4 got rdy=%b rsp=%b exp rdy=00 rsp=01", bus.req_ready, bus.rsp_valid); end
    tick();
    bus.mb_rsp_valid = 1'b0; bus.req_valid = 2'b11; #1;
    checks++; if (bus.req_ready !== 2'b10) begin failures++; $display("FAIL lock_c5 got=%b exp=10", bus.req_ready); end
    tick(); bus.req_valid = 2'b00; bus.mb_req_ready = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_hold();
    test_alternation();
    test_routing();
    test_orphan();
    test_reset_midburst();
`ifdef MODELBUF_ARB_LOCK_EN
    test_lock();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/modelbuf_read_arbiter.md
# modelbuf_read_arbiter

Shares the single model-buffer read port between `NUM_REQ` triangle-fetch requesters (scene readers working on different model instances in parallel). Forwards one `modelbuf_read_t` request per cycle using round-robin arbitration, records the granted requester in an in-order tag FIFO, and routes each returned `triangle_t`/`triangle_meta_t` beat back to the requester that issued it. Sits between the scene readers' model request/response ports and the model buffer.

## Interface
- `NUM_REQ`, default 2: number of requesters; at least 1.
- `TAG_DEPTH`, default 4: maximum outstanding model-buffer reads; power of two, at least 2.
- `clk`  in  1  clock.
- `rstn`  in  1  synchronous active-low reset.
- `req_valid`  in  [NUM_REQ]  per-requester read request valid.
- `req_ready`  out  [NUM_REQ]  per-requester request accepted.
- `req_data`  in  modelbuf_read_t [NUM_REQ]  per-requester `{model_index, triangle_index}`.
- `mb_req_valid`  out  1  request to the model buffer.
- `mb_req_ready`  in  1  model buffer accepts the request.
- `mb_req_data`  out  modelbuf_read_t  forwarded request.
- `mb_rsp_valid`  in  1  model buffer response valid.
- `mb_rsp_ready`  out  1  response consumed.
- `mb_rsp_data`  in  triangle_t  returned triangle.
- `mb_rsp_metadata`  in  triangle_meta_t  `.last` marks the model's final triangle.
- `rsp_valid`  out  [NUM_REQ]  response valid to requester i.
- `rsp_ready`  in  [NUM_REQ]  requester i accepts the response.
- `rsp_data`  out  triangle_t  `mb_rsp_data`, broadcast to all requesters.
- `rsp_metadata`  out  triangle_meta_t  `mb_rsp_metadata`, broadcast.
- `outstanding`  out  $clog2(TAG_DEPTH+1)  current tag FIFO occupancy.
- `err_orphan_rsp`  out  1  sticky flag: response arrived with no outstanding tag.

## Operation
- **Eligibility and grant.** A requester is eligible when `req_valid[i]=1`. The grant is the first eligible index strictly after `rr_ptr`, wrapping modulo NUM_REQ.
- **Request forwarding.** `mb_req_valid = (any eligible) && !fifo_full`. `mb_req_data = req_data[grant]`. `req_ready[grant] = mb_req_ready && mb_req_valid`. All other `req_ready` bits are 0.
- **Grant hold.** If `mb_req_valid=1` and `mb_req_ready=0`, the grant index is registered and held until the handshake completes, even if a higher-priority requester becomes valid. Requesters must keep `req_valid` and `req_data` stable until they see `req_ready`.
- **On request handshake.** Push the grant index into the tag FIFO. Set `rr_ptr <= grant`. Release the hold.
- **Response routing.** `head` is the FIFO head tag.
  - `rsp_valid[i] = mb_rsp_valid && !fifo_empty && head==i`.
  - `mb_rsp_ready = !fifo_empty && rsp_ready[head]`.
  - Pop the FIFO on `mb_rsp_valid && mb_rsp_ready`.
- **Full FIFO.** When the FIFO is full, no push occurs, even if a pop happens in the same cycle.
- **Empty FIFO.** When the FIFO is empty, `mb_rsp_ready=0`. If `mb_rsp_valid=1` in that state, set `err_orphan_rsp`; it stays set until reset.
- **Simultaneous push and pop** (FIFO neither empty nor full): `outstanding` is unchanged and both pointers advance. Pointers wrap modulo TAG_DEPTH.

## Timing
- **Reset**, synchronous on any cycle including mid-burst, sets:
  - `rr_ptr = NUM_REQ-1`, so requester 0 wins first.
  - FIFO empty and `outstanding = 0`.
  - Hold cleared; lock cleared, if lock is compiled in.
  - `err_orphan_rsp = 0`.
  - Consequently all of `req_ready`, `mb_req_valid`, `rsp_valid` and `mb_rsp_ready` are 0.
  - In-flight responses arriving after reset are orphans.
- **Latency.** The request path is combinational: request to `mb_req_valid` in 0 cycles. The response path is combinational: 0 cycles.
- **Throughput.** One request per cycle. One response per cycle.
- **Tag visibility.** A tag pushed in cycle N is visible at `head` in cycle N+1. A response in the same cycle as the first push is therefore an orphan.
- **Arbitration timing.** `rr_ptr` updates only on a handshake. Idle cycles do not rotate priority.

## Configuration
- `MODELBUF_ARB_LOCK_EN`
  - **Defined:** per-model locking.
    - A `lock_valid`/`lock_id` register is set on the first grant while unlocked.
    - While locked, only `lock_id` is eligible.
    - The lock clears on the response handshake where `head==lock_id && mb_rsp_metadata.last`.
    - Unlocking takes effect the next cycle; `rr_ptr` then selects the next requester.
  - **Undefined:** the lock logic is absent, and arbitration is per beat round-robin as described above.

## Test plan
- **Reset priority and alternation.** Reset, then assert `req_valid=2'b11` with `mb_req_ready=1` → grants alternate 0,1,0,1. `outstanding` climbs to 4, after which `mb_req_valid=0` until a pop.
- **Grant hold under backpressure.** Req1 alone is valid with `mb_req_ready=0` for 3 cycles; req0 raises valid in cycle 2 → `mb_req_data` stays `req_data[1]`. After the ready pulse, the next grant goes to 0.
- **Response routing with backpressure.** Grants 0,1,0; then 3 responses with `rsp_ready[1]=0` for 2 cycles → `rsp_valid` sequence 01, 10 (held 3 cycles), 01. No beat is lost.
- **Orphan detection.** `mb_rsp_valid=1` with an empty FIFO → `mb_rsp_ready=0` and `err_orphan_rsp=1` next cycle, held until `rstn=0`.
- **Reset mid-burst.** Assert `rstn=0` with 3 outstanding tags → next cycle `outstanding=0`, all valids 0, and the next grant goes to requester 0.
- **Lock mode (`MODELBUF_ARB_LOCK_EN`).** Both requesters valid and req0 is granted → only req0 is granted until its response with `last=1` is accepted. Req1 is granted in the following cycle.
